counter_bank_updown: RTL and testbench
======================================

COUNTER_BANK_UPDOWN -- requirements
Module: counter_bank_updown

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (WIDTH >= 2) SHALL be supported.
REQ-002 Parameter MODE, default MODE_WRAP, boundary behaviour (MODE_WRAP, MODE_SAT, MODE_ONESHOT) SHALL be supported.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port enable  input  1  count step request, sampled each posedge.
REQ-006 Port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 Port load  input  1  synchronous load request.
REQ-008 Port load_value  input  WIDTH  value applied on load.
REQ-009 Port limit  input  WIDTH  programmable upper bound (inclusive).
REQ-010 Port clear_flags  input  1  clears overflow/underflow sticky flags.
REQ-011 Port out  output  WIDTH  registered count value.
REQ-012 Port tc  output  1  registered terminal-count pulse, one cycle.
REQ-013 Port overflow  output  1  sticky: an up-boundary event occurred.
REQ-014 Port underflow  output  1  sticky: a down-boundary event occurred.
REQ-015 Port done  output  1  one-shot finished (MODE_ONESHOT only; else constant 0).

Function
REQ-016 Priority per cycle SHALL be reset > load > enable; no input active -> all state holds.
REQ-017 Load SHALL set out = min(load_value, limit) on the next edge, clear done, and SHALL NOT assert tc or set flags.
REQ-018 Enable with up=1 and out < limit SHALL set out = out+1; with up=0 and out > 0 SHALL set out = out-1; latency one edge.
REQ-019 Up-boundary event: enable, up=1, out >= limit; down-boundary event: enable, up=0, out == 0.
REQ-020 On up-boundary: MODE_WRAP out=0; MODE_SAT out holds (value min(out,limit)); MODE_ONESHOT out=limit and done=1.
REQ-021 On down-boundary: MODE_WRAP out=limit; MODE_SAT out holds 0; MODE_ONESHOT out holds 0 and done=1.
REQ-022 tc SHALL be 1 for exactly the cycle following any boundary event, else 0; back-to-back events give continuous tc.
REQ-023 overflow SHALL set on up-boundary, underflow on down-boundary; both hold until clear_flags or reset.
REQ-024 Simultaneous clear_flags and boundary event SHALL leave the corresponding flag set (set wins).
REQ-025 FSM (MODE_ONESHOT): states RUN, DONE; RUN->DONE on boundary event; DONE->RUN on load; in DONE enable is ignored, no tc, no flag change.
REQ-026 limit lowered below out while counting up SHALL be treated as boundary on the next up step (REQ-019 >= rule).
REQ-027 limit == 0: every enabled step is a boundary event in both directions.
REQ-028 All arithmetic SHALL be WIDTH-bit unsigned; no intermediate value wider than WIDTH+1 bits reaches out.

Reset
REQ-029 reset SHALL force out=0, tc=0, overflow=0, underflow=0, done=0, FSM=RUN on the next edge, overriding load/enable mid-operation.
REQ-030 Outputs SHALL be undefined-free from the first edge with reset asserted; no asynchronous path from reset.

Structure
REQ-031 Package counter_pkg SHALL hold the mode typedef (counter_mode_e: MODE_WRAP, MODE_SAT, MODE_ONESHOT) and the FSM state typedef.
REQ-032 Next-value/boundary logic SHALL be one combinational sub-module counter_step (inputs out, limit, up, mode; outputs next, up_bnd, dn_bnd); flags, tc, FSM live in the top.

Verification (WIDTH=4)
REQ-033 MODE_WRAP, limit=9, reset then 10 enables up -> out 1..9 then 0; tc=1 one cycle after tenth step; overflow=1.
REQ-034 MODE_SAT, limit=15, load 1, 3 enables down -> out 0,0,0; tc pulses after steps 2 and 3; underflow=1; clear_flags -> underflow=0.
REQ-035 MODE_ONESHOT, limit=3, enables up from 0 -> out 1,2,3,3; done=1 after 4th step; further enables no change; load 0 -> done=0, out=0.
REQ-036 load_value=12 with limit=5 -> out=5; simultaneous load and enable -> load wins, tc=0.
REQ-037 reset asserted mid-count (out=7) with enable and load high -> next edge out=0, all flags 0.
REQ-038 overflow boundary coincident with clear_flags -> overflow remains 1; clear_flags next cycle alone -> overflow=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the up/down counter bank: boundary-mode selector and the
// one-shot run/done state encoding.
package counter_pkg;

    // Smallest counter width the step logic is built for; narrower counters
    // would leave no room between zero and a meaningful limit.
    localparam int COUNTER_MIN_WIDTH = 2;

    // How the counter reacts when a step would cross zero or the limit.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } counter_mode_e;

    // One-shot progress: RUN counts normally, DONE freezes until a load.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } counter_state_e;

endpackage : counter_pkg

// File: rtl/counter_step.sv
// Combinational next-value and boundary detection for one counter step.
// The caller decides whether the step is actually taken; this block only
// answers "what would the count become, and is this a boundary step".
module counter_step
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] limit,
    input  logic             up,
    input  counter_mode_e    mode,
    output logic [WIDTH-1:0] next,
    output logic             up_bnd,
    output logic             dn_bnd
);

    // An up step is a boundary whenever the count has reached or passed the
    // limit (covers a limit lowered underneath the count). A down step is a
    // boundary at zero, and a zero limit makes every step a boundary.
    always_comb begin
        up_bnd = up && (out >= limit);
        dn_bnd = !up && ((out == '0) || (limit == '0));
    end

    // Select the candidate count: plain increment/decrement away from the
    // boundaries, mode-specific landing value on a boundary. Saturation and
    // one-shot both land on the limit going up, since min(out, limit) is the
    // limit whenever out >= limit.
    always_comb begin
        next = out;
        if (up) begin
            if (!up_bnd) begin
                next = out + WIDTH'(1);
            end else begin
                case (mode)
                    MODE_WRAP:    next = '0;
                    MODE_SAT:     next = limit;
                    MODE_ONESHOT: next = limit;
                    default:      next = out;
                endcase
            end
        end else begin
            if (!dn_bnd) begin
                next = out - WIDTH'(1);
            end else begin
                case (mode)
                    MODE_WRAP:    next = limit;
                    MODE_SAT:     next = '0;
                    MODE_ONESHOT: next = '0;
                    default:      next = out;
                endcase
            end
        end
    end

endmodule : counter_step

// File: rtl/counter_bank_updown.sv
// Up/down counter with programmable inclusive limit, selectable boundary
// behaviour (wrap, saturate, one-shot), a one-cycle terminal-count pulse and
// sticky overflow/underflow flags. Everything is synchronous to clk.
module counter_bank_updown
    import counter_pkg::*;
#(
    parameter int            WIDTH = 4,
    parameter counter_mode_e MODE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             overflow,
    output logic             underflow,
    output logic             done
);

    logic [WIDTH-1:0] r_out;
    logic             r_tc;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_done;
    counter_state_e   r_state;

    logic [WIDTH-1:0] w_next;
    logic             w_upBnd;
    logic             w_dnBnd;
    logic             w_stepAllowed;
    logic             w_upEvent;
    logic             w_dnEvent;
    logic [WIDTH-1:0] w_loadClamped;

    counter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .out    (r_out),
        .limit  (limit),
        .up     (up),
        .mode   (MODE),
        .next   (w_next),
        .up_bnd (w_upBnd),
        .dn_bnd (w_dnBnd)
    );

    // A step only happens when enabled, not overridden by a load, and not
    // frozen in the one-shot DONE state. Boundary events are qualified the
    // same way so tc and the flags only react to steps that really happen.
    always_comb begin
        w_stepAllowed = enable && !load &&
                        !((MODE == MODE_ONESHOT) && (r_state == ST_DONE));
        w_upEvent     = w_stepAllowed && w_upBnd;
        w_dnEvent     = w_stepAllowed && w_dnBnd;
        w_loadClamped = (load_value > limit) ? limit : load_value;
    end

    // Count register: reset beats load, load beats a step, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else if (load) begin
            r_out <= w_loadClamped;
        end else if (w_stepAllowed) begin
            r_out <= w_next;
        end
    end

    // Terminal-count pulse: high for the cycle after each boundary step, so
    // consecutive boundary steps keep it high continuously.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= w_upEvent || w_dnEvent;
        end
    end

    // Sticky flags: a boundary in the same cycle as clear_flags keeps the
    // flag set, so an event is never lost to a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_upEvent || (r_overflow  && !clear_flags);
            r_underflow <= w_dnEvent || (r_underflow && !clear_flags);
        end
    end

    // One-shot FSM: the first boundary step finishes the run, only a load
    // re-arms it. In the other modes it never leaves RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if ((MODE == MODE_ONESHOT) && (w_upEvent || w_dnEvent)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (load) begin
                        r_state <= ST_RUN;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out       = r_out;
    assign tc        = r_tc;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign done      = (MODE == MODE_ONESHOT) ? r_done : 1'b0;

endmodule : counter_bank_updown

// File: tb/tb_counter_bank_updown.sv
// Scoreboard bench: three counters (wrap, saturate, one-shot) share one
// stimulus stream; a behavioural model predicts each one and a separate
// monitor compares the registered outputs one cycle later.
module tb_counter_bank_updown;
    import counter_pkg::*;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic             tc;
        logic             ov;
        logic             un;
        logic             done;
    } expT;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] loadValue;
    logic [WIDTH-1:0] limit;
    logic             clearFlags;

    logic [WIDTH-1:0] outW, outS, outO;
    logic             tcW, tcS, tcO;
    logic             ovW, ovS, ovO;
    logic             unW, unS, unO;
    logic             doneW, doneS, doneO;

    expT qWrap[$];
    expT qSat[$];
    expT qOne[$];

    int  nCompared   = 0;
    int  nMismatched = 0;
    bit  stimDone    = 0;

    // Reference state, index 0 = wrap, 1 = saturate, 2 = one-shot
    int  mOut[3];
    bit  mTc[3];
    bit  mOv[3];
    bit  mUn[3];
    bit  mDone[3];

    counter_bank_updown #(.WIDTH(WIDTH), .MODE(MODE_WRAP)) dutWrap (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(loadValue), .limit(limit), .clear_flags(clearFlags),
        .out(outW), .tc(tcW), .overflow(ovW), .underflow(unW), .done(doneW));

    counter_bank_updown #(.WIDTH(WIDTH), .MODE(MODE_SAT)) dutSat (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(loadValue), .limit(limit), .clear_flags(clearFlags),
        .out(outS), .tc(tcS), .overflow(ovS), .underflow(unS), .done(doneS));

    counter_bank_updown #(.WIDTH(WIDTH), .MODE(MODE_ONESHOT)) dutOne (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(loadValue), .limit(limit), .clear_flags(clearFlags),
        .out(outO), .tc(tcO), .overflow(ovO), .underflow(unO), .done(doneO));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural rules for one clock edge of counter m (0 wrap, 1 sat, 2 one-shot)
    task automatic modelStep(input int m, input bit rst, input bit en, input bit u,
                             input bit ld, input int lv, input int lim, input bit clr);
        bit evUp;
        bit evDn;
        evUp = 0;
        evDn = 0;
        if (rst) begin
            mOut[m] = 0; mTc[m] = 0; mOv[m] = 0; mUn[m] = 0; mDone[m] = 0;
        end else begin
            if (ld) begin
                mOut[m]  = (lv < lim) ? lv : lim;
                mDone[m] = 0;
            end else if (en && !mDone[m]) begin
                if (u) begin
                    if (mOut[m] < lim) mOut[m] = mOut[m] + 1;
                    else begin
                        evUp = 1;
                        if (m == 0) mOut[m] = 0;
                        else mOut[m] = lim;
                        if (m == 2) mDone[m] = 1;
                    end
                end else begin
                    if (mOut[m] > 0 && lim != 0) mOut[m] = mOut[m] - 1;
                    else begin
                        evDn = 1;
                        if (m == 0) mOut[m] = lim;
                        else mOut[m] = 0;
                        if (m == 2) mDone[m] = 1;
                    end
                end
            end
            mTc[m] = evUp | evDn;
            mOv[m] = evUp | (mOv[m] & !clr);
            mUn[m] = evDn | (mUn[m] & !clr);
        end
    endtask

    // Drive one cycle of inputs, predict all three counters, queue predictions
    task automatic applyStimulus(input bit rst, input bit en, input bit u, input bit ld,
                                 input int lv, input int lim, input bit clr);
        expT e;
        reset      = rst;
        enable     = en;
        up         = u;
        load       = ld;
        loadValue  = WIDTH'(lv);
        limit      = WIDTH'(lim);
        clearFlags = clr;
        for (int m = 0; m < 3; m++) begin
            modelStep(m, rst, en, u, ld, lv, lim, clr);
            e.out  = WIDTH'(mOut[m]);
            e.tc   = mTc[m];
            e.ov   = mOv[m];
            e.un   = mUn[m];
            e.done = mDone[m];
            if (m == 0) qWrap.push_back(e);
            else if (m == 1) qSat.push_back(e);
            else qOne.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic checkField(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input expT act, input expT exp);
        checkField({tag, ".out"},       int'(act.out),  int'(exp.out));
        checkField({tag, ".tc"},        int'(act.tc),   int'(exp.tc));
        checkField({tag, ".overflow"},  int'(act.ov),   int'(exp.ov));
        checkField({tag, ".underflow"}, int'(act.un),   int'(exp.un));
        checkField({tag, ".done"},      int'(act.done), int'(exp.done));
    endtask

    // Monitor: just after each edge, compare every counter against the oldest prediction
    initial begin
        expT act;
        forever begin
            @(posedge clk);
            #1;
            if (qWrap.size() > 0) begin
                act = {outW, tcW, ovW, unW, doneW};
                checkOutput("wrap", act, qWrap.pop_front());
            end
            if (qSat.size() > 0) begin
                act = {outS, tcS, ovS, unS, doneS};
                checkOutput("sat", act, qSat.pop_front());
            end
            if (qOne.size() > 0) begin
                act = {outO, tcO, ovO, unO, doneO};
                checkOutput("oneshot", act, qOne.pop_front());
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic
    initial begin
        int lim;
        reset = 1; enable = 0; up = 0; load = 0; loadValue = '0; limit = '0; clearFlags = 0;
        for (int m = 0; m < 3; m++) begin
            mOut[m] = 0; mTc[m] = 0; mOv[m] = 0; mUn[m] = 0; mDone[m] = 0;
        end
        #2;

        // Count up through limit 9 and wrap
        applyStimulus(1, 0, 0, 0, 0, 9, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 0, 0, 9, 0);
        applyStimulus(0, 0, 1, 0, 0, 9, 0);

        // Load 1 then count down past zero, then clear the sticky flag
        applyStimulus(1, 0, 0, 0, 0, 15, 0);
        applyStimulus(0, 0, 0, 1, 1, 15, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 15, 0);
        applyStimulus(0, 0, 0, 0, 0, 15, 1);

        // One-shot to limit 3, extra enables, then reload 0
        applyStimulus(1, 0, 0, 0, 0, 3, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 0, 0, 3, 0);
        applyStimulus(0, 0, 1, 1, 0, 3, 0);

        // Load clamped to limit, and load overriding a boundary step
        applyStimulus(0, 0, 0, 1, 12, 5, 0);
        applyStimulus(0, 1, 1, 1, 12, 5, 0);
        applyStimulus(0, 1, 1, 1, 2, 5, 0);

        // Reset in the middle of a count with load and enable active
        applyStimulus(1, 0, 0, 0, 0, 15, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 1, 0, 0, 15, 0);
        applyStimulus(1, 1, 1, 1, 9, 15, 0);

        // Overflow coincident with clear, then clear alone
        applyStimulus(1, 0, 0, 0, 0, 2, 0);
        applyStimulus(0, 1, 1, 0, 0, 2, 0);
        applyStimulus(0, 1, 1, 0, 0, 2, 0);
        applyStimulus(0, 1, 1, 0, 0, 2, 1);
        applyStimulus(0, 0, 1, 0, 0, 2, 1);

        // Limit lowered under the count, and zero limit in both directions
        applyStimulus(0, 0, 0, 1, 9, 12, 0);
        applyStimulus(0, 1, 1, 0, 0, 4, 0);
        applyStimulus(0, 1, 0, 1, 9, 12, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);

        // Randomized traffic
        lim = 9;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) lim = $urandom_range(0, MAXV);
            applyStimulus($urandom_range(0, 49) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, MAXV),
                          lim,
                          $urandom_range(0, 11) == 0);
        end
        enable = 0; load = 0; reset = 0; clearFlags = 0;
        stimDone = 1;
    end

    // Drain the scoreboard with a bounded wait, then report
    initial begin
        wait (stimDone);
        for (int i = 0; i < 10; i++) begin
            if (qWrap.size() == 0 && qSat.size() == 0 && qOne.size() == 0) break;
            @(posedge clk);
            #3;
        end
        if (qWrap.size() != 0 || qSat.size() != 0 || qOne.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL drain: got %0d predictions left, expected 0",
                     qWrap.size() + qSat.size() + qOne.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no end of stimulus, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule : tb_counter_bank_updown
